lc3b_mem_arbiter: RTL and testbench



---
 rtl/lc3b_mem_arbiter_if.sv | 52 +++++
 rtl/lc3b_mem_arbiter.sv | 114 +++++++++++
 tb/tb_lc3b_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_mem_arbiter_if.sv
// Shared types plus the bus bundle between the two L1 cache controllers, the
// arbiter and physical memory.
// Ports: I-cache read channel, D-cache read/write channel, one pmem channel.
// Modport slave is the arbiter's view; modport master is the surrounding system.
package lc3b_types;
   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_cache_line;
endpackage

interface lc3b_mem_arbiter_if;
   import lc3b_types::*;

   // I-cache side
   logic           i_pmem_read;
   lc3b_word       i_pmem_address;
   lc3b_cache_line i_pmem_rdata;
   logic           i_pmem_resp;

   // D-cache side
   logic           d_pmem_read;
   logic           d_pmem_write;
   lc3b_word       d_pmem_address;
   lc3b_cache_line d_pmem_wdata;
   lc3b_cache_line d_pmem_rdata;
   logic           d_pmem_resp;

   // physical memory side
   logic           pmem_read;
   logic           pmem_write;
   lc3b_word       pmem_address;
   lc3b_cache_line pmem_wdata;
   lc3b_cache_line pmem_rdata;
   logic           pmem_resp;

   modport slave (
      input  i_pmem_read, i_pmem_address,
      input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      input  pmem_rdata, pmem_resp,
      output i_pmem_rdata, i_pmem_resp,
      output d_pmem_rdata, d_pmem_resp,
      output pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   modport master (
      output i_pmem_read, i_pmem_address,
      output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      output pmem_rdata, pmem_resp,
      input  i_pmem_rdata, i_pmem_resp,
      input  d_pmem_rdata, d_pmem_resp,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata
   );
endinterface

// File: rtl/lc3b_mem_arbiter.sv
// Round-robin arbiter giving the I-cache and D-cache turns on one line-wide pmem port.
// Latency: strobe one cycle after grant; requester resp one cycle after pmem_resp.
// Backpressure: one transaction in flight; losing/late requester holds its request.
// Ports: clk, reset (async, active-high), bus (slave view of lc3b_mem_arbiter_if).
module lc3b_mem_arbiter
   import lc3b_types::*;
(
   input  logic               clk,
   input  logic               reset,
   lc3b_mem_arbiter_if.slave  bus
);

   // Lines are 16 bytes, so the low nibble of any address is dropped.
   localparam lc3b_word LINE_MASK = 16'hFFF0;

   typedef enum logic [2:0] {
      IDLE,
      I_MEM,
      D_MEM,
      I_RESP,
      D_RESP
   } state_t;

   state_t         state_q, state_d;
   logic           last_grant_q, last_grant_d;   // 0 = I went last, 1 = D went last
   logic           op_write_q, op_write_d;       // frozen D op for the whole transaction
   lc3b_word       addr_q, addr_d;
   lc3b_cache_line wdata_q, wdata_d;
   lc3b_cache_line line_q, line_d;

   logic i_req;
   logic d_req;
   logic grant_i;
   logic grant_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b0;
         op_write_q   <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         line_q       <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_write_q   <= op_write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         line_q       <= line_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op_write_d   = op_write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      line_d       = line_q;

      i_req = bus.i_pmem_read;
      d_req = bus.d_pmem_read | bus.d_pmem_write;
      // On a tie, D wins only if I had the previous turn.
      grant_d = d_req & (~i_req | ~last_grant_q);
      grant_i = i_req & ~grant_d;

      case (state_q)
         IDLE: begin
            if (grant_i) begin
               state_d      = I_MEM;
               addr_d       = bus.i_pmem_address & LINE_MASK;
               last_grant_d = 1'b0;
            end else if (grant_d) begin
               state_d      = D_MEM;
               addr_d       = bus.d_pmem_address & LINE_MASK;
               wdata_d      = bus.d_pmem_wdata;
               // read+write together resolves to a write-back
               op_write_d   = bus.d_pmem_write;
               last_grant_d = 1'b1;
            end
         end
         I_MEM: begin
            if (bus.pmem_resp) begin
               line_d  = bus.pmem_rdata;
               state_d = I_RESP;
            end
         end
         D_MEM: begin
            if (bus.pmem_resp) begin
               if (!op_write_q) begin
                  line_d = bus.pmem_rdata;
               end
               state_d = D_RESP;
            end
         end
         I_RESP:  state_d = IDLE;
         D_RESP:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobes and resps decode the state register only, so they never follow
   // requester inputs combinationally.
   assign bus.pmem_read    = (state_q == I_MEM) | ((state_q == D_MEM) & ~op_write_q);
   assign bus.pmem_write   = (state_q == D_MEM) & op_write_q;
   assign bus.pmem_address = addr_q;
   assign bus.pmem_wdata   = wdata_q;
   assign bus.i_pmem_resp  = (state_q == I_RESP);
   assign bus.d_pmem_resp  = (state_q == D_RESP);
   assign bus.i_pmem_rdata = line_q;
   assign bus.d_pmem_rdata = line_q;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Directed bench for lc3b_mem_arbiter: a transaction-level reference model
// is compared every cycle, plus literal expectations per scenario.
module tb_lc3b_mem_arbiter;
   import lc3b_types::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lc3b_mem_arbiter_if bus();

   lc3b_mem_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   localparam lc3b_cache_line LINE_A = {16'hDEAD, 96'h0123_4567_89AB_CDEF_0011_2233, 16'hBEEF};
   localparam lc3b_cache_line LINE_B = {8{16'h5A3C}};
   localparam lc3b_cache_line WD_A5  = {16{8'hA5}};
   localparam lc3b_cache_line WD_C3  = {16{8'hC3}};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- memory responder ----------------
   int             mem_lat    = 1;
   lc3b_cache_line mem_line   = '0;
   bit             mem_manual = 1'b0;
   bit             mem_force  = 1'b0;
   int             mem_cnt    = 0;

   always @(negedge clk) begin
      if (mem_manual) begin
         bus.pmem_resp = mem_force;
         mem_cnt = 0;
      end else if (bus.pmem_resp === 1'b1) begin
         bus.pmem_resp = 1'b0;
         mem_cnt = 0;
      end else if (bus.pmem_read === 1'b1 || bus.pmem_write === 1'b1) begin
         mem_cnt++;
         bus.pmem_resp = (mem_cnt >= mem_lat);
         if (mem_cnt >= mem_lat) bus.pmem_rdata = mem_line;
      end else begin
         mem_cnt = 0;
         bus.pmem_resp = 1'b0;
      end
   end

   // ---------------- reference model ----------------
   // One record describes the transaction in progress: who owns the port,
   // whether it writes, and whether memory has already answered.
   logic           m_busy, m_who, m_wr, m_done, m_last;
   lc3b_word       m_addr;
   lc3b_cache_line m_wdata, m_line;

   function automatic lc3b_word line_of(input lc3b_word a);
      return {a[15:4], 4'h0};
   endfunction

   wire want_i = bus.i_pmem_read;
   wire want_d = bus.d_pmem_read | bus.d_pmem_write;
   wire pick_d = (want_i && want_d) ? ~m_last : want_d;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy <= 1'b0; m_who <= 1'b0; m_wr <= 1'b0; m_done <= 1'b0; m_last <= 1'b0;
         m_addr <= '0; m_wdata <= '0; m_line <= '0;
      end else if (!m_busy) begin
         if (want_i || want_d) begin
            m_busy <= 1'b1;
            m_done <= 1'b0;
            m_who  <= pick_d;
            m_last <= pick_d;
            m_wr   <= pick_d & bus.d_pmem_write;
            m_addr <= pick_d ? line_of(bus.d_pmem_address) : line_of(bus.i_pmem_address);
            if (pick_d) m_wdata <= bus.d_pmem_wdata;
         end
      end else if (m_done) begin
         m_busy <= 1'b0;
      end else if (bus.pmem_resp) begin
         m_done <= 1'b1;
         if (!m_wr) m_line <= bus.pmem_rdata;
      end
   end

   // ---------------- compare + monitor ----------------
   int  cyc = 0;
   int  rd_cycles = 0, wr_cycles = 0, i_resps = 0, d_resps = 0;
   int  rise_cyc = 0, i_resp_cyc = 0, d_resp_cyc = 0;
   lc3b_word       rise_addr  = '0;
   lc3b_cache_line rise_wdata = '0;
   bit  prev_strobe = 1'b0;
   byte order_q[$];

   always @(negedge clk) begin
      logic e_rd, e_wr, e_ir, e_dr;
      cyc++;
      e_rd = m_busy & ~m_done & ~m_wr;
      e_wr = m_busy & ~m_done & m_wr;
      e_ir = m_busy & m_done & ~m_who;
      e_dr = m_busy & m_done & m_who;
      check("pmem_read",    bus.pmem_read,    e_rd);
      check("pmem_write",   bus.pmem_write,   e_wr);
      check("i_pmem_resp",  bus.i_pmem_resp,  e_ir);
      check("d_pmem_resp",  bus.d_pmem_resp,  e_dr);
      check("pmem_address", bus.pmem_address, m_addr);
      check("pmem_wdata",   bus.pmem_wdata,   m_wdata);
      if (e_ir) check("i_pmem_rdata", bus.i_pmem_rdata, m_line);
      if (e_dr) check("d_pmem_rdata", bus.d_pmem_rdata, m_line);

      if (bus.pmem_read === 1'b1)  rd_cycles++;
      if (bus.pmem_write === 1'b1) wr_cycles++;
      if ((bus.pmem_read === 1'b1 || bus.pmem_write === 1'b1) && !prev_strobe) begin
         rise_cyc   = cyc;
         rise_addr  = bus.pmem_address;
         rise_wdata = bus.pmem_wdata;
      end
      prev_strobe = (bus.pmem_read === 1'b1 || bus.pmem_write === 1'b1);
      if (bus.i_pmem_resp === 1'b1) begin i_resps++; i_resp_cyc = cyc; order_q.push_back("I"); end
      if (bus.d_pmem_resp === 1'b1) begin d_resps++; d_resp_cyc = cyc; order_q.push_back("D"); end
   end

   // ---------------- stimulus helpers ----------------
   task automatic clear_stats();
      @(posedge clk); #1;
      rd_cycles = 0; wr_cycles = 0; i_resps = 0; d_resps = 0;
      order_q.delete();
   endtask

   function automatic logic [15:0] first_two();
      if (order_q.size() < 2) return 16'h0;
      return {order_q[0], order_q[1]};
   endfunction

   task automatic i_request(input lc3b_word a, output lc3b_cache_line got);
      bit ok = 1'b0;
      got = '0;
      bus.i_pmem_read = 1'b1;
      bus.i_pmem_address = a;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.i_pmem_resp === 1'b1) begin ok = 1'b1; got = bus.i_pmem_rdata; break; end
      end
      bus.i_pmem_read = 1'b0;
      check("i_req_completes", ok, 1'b1);
   endtask

   task automatic d_request(input lc3b_word a, input lc3b_cache_line wd, input bit rd, input bit wr,
                            output lc3b_cache_line got);
      bit ok = 1'b0;
      got = '0;
      bus.d_pmem_read = rd;
      bus.d_pmem_write = wr;
      bus.d_pmem_address = a;
      bus.d_pmem_wdata = wd;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.d_pmem_resp === 1'b1) begin ok = 1'b1; got = bus.d_pmem_rdata; break; end
      end
      bus.d_pmem_read = 1'b0;
      bus.d_pmem_write = 1'b0;
      check("d_req_completes", ok, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   // ---------------- directed scenarios ----------------
   initial begin
      lc3b_cache_line gi, gd;
      bit saw_strobe;
      bus.i_pmem_read = 1'b0; bus.i_pmem_address = '0;
      bus.d_pmem_read = 1'b0; bus.d_pmem_write = 1'b0;
      bus.d_pmem_address = '0; bus.d_pmem_wdata = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_pmem_read",   bus.pmem_read,    1'b0);
      check("rst_pmem_write",  bus.pmem_write,   1'b0);
      check("rst_pmem_addr",   bus.pmem_address, 16'h0);
      check("rst_i_rdata",     bus.i_pmem_rdata, 128'h0);
      reset = 1'b0;

      // tie straight after reset: D first, then I after one idle cycle
      mem_lat = 2; mem_line = LINE_B;
      clear_stats();
      @(negedge clk);
      fork
         i_request(16'h0040, gi);
         d_request(16'h0080, '0, 1'b1, 1'b0, gd);
      join
      repeat (2) @(negedge clk);
      check("tie1_order", first_two(), {"D", "I"});
      check("tie1_gap",   rise_cyc - d_resp_cyc, 2);

      // I read at 0x1234, memory takes 4 cycles
      mem_lat = 4; mem_line = LINE_A;
      clear_stats();
      @(negedge clk);
      i_request(16'h1234, gi);
      repeat (2) @(negedge clk);
      check("iread_line",    gi, LINE_A);
      check("iread_addr",    rise_addr, 16'h1230);
      check("iread_rd_cyc",  rd_cycles, 4);
      check("iread_i_resps", i_resps, 1);
      check("iread_d_resps", d_resps, 0);

      // D write-back at 0x8008
      mem_lat = 1;
      clear_stats();
      @(negedge clk);
      d_request(16'h8008, WD_A5, 1'b0, 1'b1, gd);
      repeat (2) @(negedge clk);
      check("dwr_addr",    rise_addr, 16'h8000);
      check("dwr_wdata",   rise_wdata, WD_A5);
      check("dwr_wr_cyc",  wr_cycles, 1);
      check("dwr_rd_cyc",  rd_cycles, 0);
      check("dwr_d_resps", d_resps, 1);

      // tie again, D went last, so I first
      mem_lat = 1; mem_line = LINE_B;
      clear_stats();
      @(negedge clk);
      fork
         i_request(16'h2000, gi);
         d_request(16'h3000, '0, 1'b1, 1'b0, gd);
      join
      repeat (2) @(negedge clk);
      check("tie2_order", first_two(), {"I", "D"});
      check("tie2_d_line", gd, LINE_B);

      // D arrives while I is in flight; I address changes mid-transaction
      mem_lat = 5; mem_line = LINE_A;
      clear_stats();
      @(negedge clk);
      fork
         i_request(16'h4448, gi);
         begin
            repeat (2) @(negedge clk);
            bus.i_pmem_address = 16'hFFFF;
            @(negedge clk);
            check("busy_hold_addr", bus.pmem_address, 16'h4440);
            d_request(16'h5550, '0, 1'b1, 1'b0, gd);
         end
      join
      repeat (2) @(negedge clk);
      check("busy_order",  first_two(), {"I", "D"});
      check("busy_d_gap",  rise_cyc - i_resp_cyc, 2);
      check("busy_d_addr", rise_addr, 16'h5550);

      // read and write together is a write
      mem_lat = 2;
      clear_stats();
      @(negedge clk);
      d_request(16'h666C, WD_C3, 1'b1, 1'b1, gd);
      repeat (2) @(negedge clk);
      check("rw_rd_cyc", rd_cycles, 0);
      check("rw_wr_cyc", wr_cycles, 2);
      check("rw_wdata",  rise_wdata, WD_C3);

      // reset in the middle of a D read, then a stray pmem_resp in IDLE
      mem_lat = 20;
      clear_stats();
      @(negedge clk);
      bus.d_pmem_read = 1'b1; bus.d_pmem_address = 16'h7770;
      saw_strobe = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.pmem_read === 1'b1) begin saw_strobe = 1'b1; break; end
      end
      check("rst_mid_started", saw_strobe, 1'b1);
      @(negedge clk); #2;
      mem_manual = 1'b1; mem_force = 1'b0;
      reset = 1'b1;
      bus.d_pmem_read = 1'b0;
      #1;
      check("rst_mid_read",  bus.pmem_read,    1'b0);
      check("rst_mid_write", bus.pmem_write,   1'b0);
      check("rst_mid_dresp", bus.d_pmem_resp,  1'b0);
      check("rst_mid_addr",  bus.pmem_address, 16'h0);
      check("rst_mid_line",  bus.d_pmem_rdata, 128'h0);
      @(negedge clk); #2;
      reset = 1'b0;
      @(negedge clk); #2;
      mem_force = 1'b1;
      @(negedge clk); #2;
      mem_force = 1'b0;
      @(negedge clk); #2;
      mem_manual = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_no_dresp", d_resps, 0);
      check("rst_no_iresp", i_resps, 0);

      mem_lat = 1; mem_line = LINE_B;
      clear_stats();
      @(negedge clk);
      i_request(16'h0105, gi);
      repeat (2) @(negedge clk);
      check("post_rst_line",   gi, LINE_B);
      check("post_rst_addr",   rise_addr, 16'h0100);
      check("post_rst_iresps", i_resps, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
